vfpu_norm_round: RTL and testbench

// - Post-add stage directly downstream of the vFPU adder.
// - Takes the adder's pre-normalised sign/exponent/mantissa and normalises it (1-bit right or LZC-driven left shift).
// - Rounds to nearest-even, handles exponent overflow/underflow and packs an IEEE-754 binary result.
// - Multi-cycle FSM handshaking on the adder's done pulse; result goes to the vFPU streamer output.

---
 rtl/vfpu_norm_round.sv | 144 ++++++++++++++
 tb/tb_vfpu_norm_round.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/vfpu_norm_round.sv
// Normalise / round-to-nearest-even / pack stage that sits after the vFPU adder.
// Optional status flags output {overflow, underflow, inexact} when VFPU_NORM_STATUS_EN is defined.
module vfpu_norm_round #(
    parameter int FP_EXP_WIDTH   = 8,
    parameter int FP_MANT_WIDTH  = 23,
    parameter int PRENORM_EXP_W  = 10,
    parameter int PRENORM_MANT_W = 28
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                valid_i,
    input  logic                                signPreNorm_i,
    input  logic [PRENORM_EXP_W-1:0]            exponentPreNorm_i,
    input  logic [PRENORM_MANT_W-1:0]           mantissaPreNorm_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic [FP_EXP_WIDTH+FP_MANT_WIDTH:0] result_o
`ifdef VFPU_NORM_STATUS_EN
    ,
    output logic [2:0]                          flags_o
`endif
);

    localparam int NW  = PRENORM_MANT_W - 1;
    localparam int LZW = $clog2(NW);
    localparam int FW1 = FP_MANT_WIDTH + 1;
    localparam logic [PRENORM_EXP_W-1:0] EXP_MAX = PRENORM_EXP_W'((1 << FP_EXP_WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t                     state;
    logic                       sign_q;
    logic [PRENORM_EXP_W-1:0]   exp_q;
    logic [PRENORM_MANT_W-1:0]  mant_q;
    logic                       n_sign_q;
    logic                       n_zero_q;
    logic [PRENORM_EXP_W-1:0]   n_exp_q;
    logic [NW-1:0]              n_mant_q;

    logic [LZW-1:0]             lz;
    logic [NW-1:0]              shifted;
    logic [NW-1:0]              norm_mant;
    logic [PRENORM_EXP_W-1:0]   norm_exp;
    logic                       norm_zero;

    // Sticky is parked outside the shifter so it can never be promoted into G or R.
    always_comb begin
        lz = '0;
        for (int i = 0; i < NW; i++) begin
            if (mant_q[i]) lz = LZW'(NW - 1 - i);
        end
        shifted   = {mant_q[NW-1:1], 1'b0} << lz;
        norm_zero = (mant_q == '0);
        if (mant_q[PRENORM_MANT_W-1]) begin
            norm_mant = {mant_q[PRENORM_MANT_W-1:2], mant_q[1] | mant_q[0]};
            norm_exp  = exp_q + PRENORM_EXP_W'(1);
        end else begin
            norm_mant = shifted | NW'(mant_q[0]);
            norm_exp  = exp_q - PRENORM_EXP_W'(lz);
        end
    end

    logic                              g, r, s, lsb, inc, hidden;
    logic [FW1-1:0]                    frac_sum;
    logic [FP_MANT_WIDTH-1:0]          rnd_frac;
    logic [PRENORM_EXP_W-1:0]          rnd_exp;
    logic                              ovf, unf;
    logic [FP_EXP_WIDTH+FP_MANT_WIDTH:0] res_next;

    // A missing hidden bit (only sticky survived) cannot be packed as a normal number, so it flushes.
    always_comb begin
        g        = n_mant_q[2];
        r        = n_mant_q[1];
        s        = n_mant_q[0];
        lsb      = n_mant_q[3];
        hidden   = n_mant_q[NW-1];
        inc      = g & (r | s | lsb);
        frac_sum = {1'b0, n_mant_q[FP_MANT_WIDTH+2:3]} + FW1'(inc);
        rnd_exp  = n_exp_q + PRENORM_EXP_W'(frac_sum[FP_MANT_WIDTH]);
        rnd_frac = frac_sum[FP_MANT_WIDTH] ? '0 : frac_sum[FP_MANT_WIDTH-1:0];
        ovf      = !n_zero_q && ($signed(rnd_exp) >= $signed(EXP_MAX));
        unf      = !n_zero_q && !ovf &&
                   (($signed(rnd_exp) < $signed(PRENORM_EXP_W'(1))) || !hidden);
        res_next = {n_sign_q, rnd_exp[FP_EXP_WIDTH-1:0], rnd_frac};
        if (n_zero_q)
            res_next = '0;
        else if (ovf)
            res_next = {n_sign_q, {FP_EXP_WIDTH{1'b1}}, {FP_MANT_WIDTH{1'b0}}};
        else if (unf)
            res_next = {n_sign_q, {FP_EXP_WIDTH{1'b0}}, {FP_MANT_WIDTH{1'b0}}};
    end

`ifdef VFPU_NORM_STATUS_EN
    logic [2:0] flags_next;
    always_comb begin
        flags_next = {ovf, unf, g | r | s | ovf | unf};
    end
`endif

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            done_o   <= 1'b0;
            result_o <= '0;
`ifdef VFPU_NORM_STATUS_EN
            flags_o  <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        sign_q <= signPreNorm_i;
                        exp_q  <= exponentPreNorm_i;
                        mant_q <= mantissaPreNorm_i;
                        state  <= NORM;
                    end
                end
                NORM: begin
                    n_sign_q <= sign_q & ~norm_zero;
                    n_zero_q <= norm_zero;
                    n_exp_q  <= norm_exp;
                    n_mant_q <= norm_mant;
                    state    <= ROUND;
                end
                ROUND: begin
                    result_o <= res_next;
`ifdef VFPU_NORM_STATUS_EN
                    flags_o  <= flags_next;
`endif
                    done_o   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vfpu_norm_round.sv
// Directed-vector bench for vfpu_norm_round: latency, rounding, range handling, reset and busy drop.
// Flags are checked only when VFPU_NORM_STATUS_EN is defined.
module tb_vfpu_norm_round;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        sign = 1'b0;
    logic [9:0]  expIn = '0;
    logic [27:0] mant = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
`ifdef VFPU_NORM_STATUS_EN
    logic [2:0]  flags;
`endif

    int checkCount = 0;
    int passCount  = 0;

    vfpu_norm_round dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .valid_i           (valid),
        .signPreNorm_i     (sign),
        .exponentPreNorm_i (expIn),
        .mantissaPreNorm_i (mant),
        .busy_o            (busy),
        .done_o            (done),
        .result_o          (result)
`ifdef VFPU_NORM_STATUS_EN
        ,
        .flags_o           (flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checkCount++;
        if (got === want)
            passCount++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    endtask

    // Issue one operand for a single cycle; the bench is left at cycle 1 (just after capture).
    task automatic applyStimulus(input logic s, input logic [9:0] e, input logic [27:0] m);
        @(negedge clk);
        sign  = s;
        expIn = e;
        mant  = m;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic s, input logic [9:0] e, input logic [27:0] m,
                         input logic [31:0] wantRes, input logic [2:0] wantFlags);
        int cyc;
        applyStimulus(s, e, m);
        checkOutput({tag, ".busy1"}, 64'(busy), 64'd1);
        cyc = 1;
        while (!done && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({tag, ".latency"}, 64'(cyc), 64'd3);
        checkOutput({tag, ".busyDone"}, 64'(busy), 64'd1);
        checkOutput({tag, ".result"}, 64'(result), 64'(wantRes));
`ifdef VFPU_NORM_STATUS_EN
        checkOutput({tag, ".flags"}, 64'(flags), 64'(wantFlags));
`endif
        @(posedge clk);
        #1;
        checkOutput({tag, ".donePulse"}, 64'(done), 64'd0);
        checkOutput({tag, ".idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int doneCount;
        logic [31:0] seenRes;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.result", 64'(result), 64'd0);
        rst = 1'b0;

        runOp("onePlusOne",  1'b0, 10'd127, 28'h8000000, 32'h40000000, 3'b000);
        runOp("cancel",      1'b1, 10'd127, 28'h0200000, 32'hBD000000, 3'b000);
        runOp("tieEvenUp",   1'b0, 10'd127, {2'b01, 23'h7FFFFF, 3'b100}, 32'h40000000, 3'b001);
        runOp("overflow",    1'b0, 10'd254, 28'h8000000, 32'h7F800000, 3'b101);
        runOp("exactZero",   1'b1, 10'd100, 28'h0000000, 32'h00000000, 3'b000);
        runOp("underflow",   1'b1, 10'd3,   28'h0000008, 32'h80000000, 3'b011);
        runOp("exactOneHalf",1'b0, 10'd127, {2'b01, 23'h400000, 3'b000}, 32'h3FC00000, 3'b000);
        runOp("tieEvenDown", 1'b0, 10'd127, {2'b01, 23'h000002, 3'b100}, 32'h3F800002, 3'b001);
        runOp("roundUpGS",   1'b0, 10'd127, {2'b01, 23'h000000, 3'b101}, 32'h3F800001, 3'b001);
        runOp("carryThree",  1'b0, 10'd127, {2'b11, 23'h000000, 3'b100}, 32'h40400000, 3'b001);
        runOp("leftOneRnd",  1'b1, 10'd127, 28'h2000003, 32'hBF000001, 3'b001);

        // A second valid while busy must be dropped, not queued behind the first.
        applyStimulus(1'b0, 10'd127, 28'h8000000);
        @(negedge clk);
        sign  = 1'b1;
        mant  = 28'h0000000;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        doneCount = 0;
        seenRes   = '0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                doneCount++;
                seenRes = result;
            end
        end
        checkOutput("busyDrop.doneCount", 64'(doneCount), 64'd1);
        checkOutput("busyDrop.result", 64'(seenRes), 64'h40000000);
        checkOutput("busyDrop.held", 64'(result), 64'h40000000);

        // Reset in cycle 2 of an operation discards it.
        applyStimulus(1'b1, 10'd127, 28'h0200000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midReset.busy", 64'(busy), 64'd0);
        checkOutput("midReset.done", 64'(done), 64'd0);
        checkOutput("midReset.result", 64'(result), 64'd0);
        doneCount = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (done) doneCount++;
        end
        checkOutput("midReset.noDone", 64'(doneCount), 64'd0);

        runOp("afterReset", 1'b0, 10'd127, 28'h8000000, 32'h40000000, 3'b000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
